// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the byte-fed instruction sequencer: opcodes, states, field layout.
package instr_sequencer_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned OPCODE_W   = 3;
  localparam int unsigned STATE_W    = 2;

  // Instruction byte layout: [7:5] opcode, [4] rd, [3] rs1, [2] rs2, [1:0] ignored
  localparam int unsigned OPCODE_MSB = 7;
  localparam int unsigned OPCODE_LSB = 5;
  localparam int unsigned RD_BIT     = 4;
  localparam int unsigned RS1_BIT    = 3;
  localparam int unsigned RS2_BIT    = 2;
  localparam int unsigned IGN_MSB    = 1;
  localparam int unsigned IGN_LSB    = 0;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 3'b000,
    OP_LDI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MOV = 3'b111
  } opcode_t;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH = 2'b00,
    ST_IMM   = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WB    = 2'b11
  } state_t;

  // Decoded instruction held for the duration of one operation
  typedef struct packed {
    opcode_t opcode;
    logic    rd;
    logic    rs1;
    logic    rs2;
  } instr_t;

  // Opcodes that produce ALU status and therefore update the flags
  function automatic logic is_alu_op(input opcode_t op);
    logic alu;
    alu = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: alu = 1'b1;
      default:                               alu = 1'b0;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/instr_sequencer_alu8.sv
// Combinational 8-bit ALU: arithmetic with carry/borrow, bitwise logic, zero detect.
module alu8
  import instr_sequencer_pkg::*;
(
  input  opcode_t           opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum_wide;

  // Carry-out of the widened sum is the ADD carry
  assign sum_wide = {1'b0, a} + {1'b0, b};

  // Result and carry per opcode; non-ALU opcodes yield zero with carry clear
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum_wide[DATA_W-1:0];
        carry  = sum_wide[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Byte-stream instruction sequencer driving a two-entry external register file.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr_data,
  output logic              instr_ready,
  output logic              rf_read_register1,
  output logic              rf_read_register2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic              rf_write_enable,
  output logic              rf_write_register,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              busy,
  output logic              op_done,
  output logic              flag_zero,
  output logic              flag_carry
);

  state_t            state;
  state_t            state_next;
  instr_t            instr_in;
  instr_t            instr_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] exec_result;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic              accept;
  logic              unused_instr_bits;

  // Low instruction bits carry no meaning
  assign unused_instr_bits = ^instr_data[IGN_MSB:IGN_LSB];

  assign accept = instr_valid & instr_ready;

  // Field extraction from the incoming instruction byte
  always_comb begin
    instr_in.opcode = opcode_t'(instr_data[OPCODE_MSB:OPCODE_LSB]);
    instr_in.rd     = instr_data[RD_BIT];
    instr_in.rs1    = instr_data[RS1_BIT];
    instr_in.rs2    = instr_data[RS2_BIT];
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: LDI detours through IMM to collect its immediate byte
  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: begin
        if (accept) begin
          state_next = (instr_in.opcode == OP_LDI) ? ST_IMM : ST_EXEC;
        end
      end
      ST_IMM: begin
        if (accept) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = ST_FETCH;
      default: state_next = ST_FETCH;
    endcase
  end

  // State-decoded outputs; reset masks the handshake and any pending write
  always_comb begin
    instr_ready       = 1'b0;
    rf_read_register1 = 1'b0;
    rf_read_register2 = 1'b0;
    rf_write_enable   = 1'b0;
    rf_write_register = 1'b0;
    rf_write_data     = '0;
    op_done           = 1'b0;
    busy              = (state != ST_FETCH);
    case (state)
      ST_FETCH, ST_IMM: begin
        instr_ready = ~reset;
      end
      ST_EXEC: begin
        rf_read_register1 = instr_q.rs1;
        rf_read_register2 = instr_q.rs2;
      end
      ST_WB: begin
        op_done           = ~reset;
        rf_write_enable   = ~reset & (instr_q.opcode != OP_NOP);
        rf_write_register = instr_q.rd;
        rf_write_data     = result_q;
      end
      default: begin
        instr_ready = 1'b0;
      end
    endcase
  end

  // Value computed in EXEC: immediate, register copy, or ALU output
  always_comb begin
    exec_result = alu_result;
    case (instr_q.opcode)
      OP_LDI:  exec_result = imm_q;
      OP_MOV:  exec_result = rf_read_data1;
      default: exec_result = alu_result;
    endcase
  end

  alu8 u_alu (
    .opcode (instr_q.opcode),
    .a      (rf_read_data1),
    .b      (rf_read_data2),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Datapath registers: latched instruction, immediate, result and flags
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q    <= instr_t'(0);
      imm_q      <= '0;
      result_q   <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      if (accept && (state == ST_FETCH)) begin
        instr_q <= instr_in;
      end
      if (accept && (state == ST_IMM)) begin
        imm_q <= instr_data;
      end
      if (state == ST_EXEC) begin
        result_q <= exec_result;
        if (is_alu_op(instr_q.opcode)) begin
          flag_zero  <= alu_zero;
          flag_carry <= alu_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer with a behavioural two-entry register file.
module tb_instr_sequencer;

  localparam logic [2:0] T_NOP = 3'd0;
  localparam logic [2:0] T_LDI = 3'd1;
  localparam logic [2:0] T_ADD = 3'd2;
  localparam logic [2:0] T_SUB = 3'd3;
  localparam logic [2:0] T_AND = 3'd4;
  localparam logic [2:0] T_OR  = 3'd5;
  localparam logic [2:0] T_XOR = 3'd6;
  localparam logic [2:0] T_MOV = 3'd7;

  logic       clock;
  logic       reset;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic       instr_ready;
  logic       rf_read_register1;
  logic       rf_read_register2;
  logic [7:0] rf_read_data1;
  logic [7:0] rf_read_data2;
  logic       rf_write_enable;
  logic       rf_write_register;
  logic [7:0] rf_write_data;
  logic       busy;
  logic       op_done;
  logic       flag_zero;
  logic       flag_carry;

  typedef struct {
    logic       we;
    logic       rd;
    logic [7:0] data;
    logic       z;
    logic       c;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  exp_t        rst_e;
  logic [7:0]  rf [2];
  logic [7:0]  m_rf [2];
  logic        m_z;
  logic        m_c;
  int          n_tests;
  int          n_fail;
  int unsigned cyc;
  int unsigned last_accept;
  int unsigned first_acc;
  int unsigned prev_end;

  instr_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .instr_valid       (instr_valid),
    .instr_data        (instr_data),
    .instr_ready       (instr_ready),
    .rf_read_register1 (rf_read_register1),
    .rf_read_register2 (rf_read_register2),
    .rf_read_data1     (rf_read_data1),
    .rf_read_data2     (rf_read_data2),
    .rf_write_enable   (rf_write_enable),
    .rf_write_register (rf_write_register),
    .rf_write_data     (rf_write_data),
    .busy              (busy),
    .op_done           (op_done),
    .flag_zero         (flag_zero),
    .flag_carry        (flag_carry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // External register file: combinational read, clocked write
  assign rf_read_data1 = rf[rf_read_register1];
  assign rf_read_data2 = rf[rf_read_register2];
  always @(posedge clock) if (rf_write_enable) rf[rf_write_register] <= rf_write_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one instruction against the bench's register/flag model
  function automatic exp_t model_op(input logic [2:0] op, input logic rd, input logic rs1,
                                    input logic rs2, input logic [7:0] imm);
    exp_t       e;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] s;
    a = m_rf[rs1];
    b = m_rf[rs2];
    e.we = 1'b1; e.rd = rd; e.data = 8'h00; e.z = m_z; e.c = m_c;
    case (op)
      T_NOP: e.we = 1'b0;
      T_LDI: e.data = imm;
      T_ADD: begin s = {1'b0, a} + {1'b0, b}; e.data = s[7:0]; e.c = s[8]; e.z = (s[7:0] == 8'h00); end
      T_SUB: begin e.data = a - b; e.c = (a < b); e.z = (e.data == 8'h00); end
      T_AND: begin e.data = a & b; e.c = 1'b0; e.z = (e.data == 8'h00); end
      T_OR:  begin e.data = a | b; e.c = 1'b0; e.z = (e.data == 8'h00); end
      T_XOR: begin e.data = a ^ b; e.c = 1'b0; e.z = (e.data == 8'h00); end
      default: e.data = a;
    endcase
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    instr_valid = 1'b1;
    instr_data  = b;
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!instr_ready) check_eq("accept_timeout", 32'(instr_ready), 32'(1));
    else begin
      @(posedge clock);
      last_accept = cyc;
    end
  endtask

  task automatic send_instr(input logic [2:0] op, input logic rd, input logic rs1,
                            input logic rs2, input logic [7:0] imm, output int unsigned first);
    exp_t e;
    e = model_op(op, rd, rs1, rs2, imm);
    sb.push_back(e);
    if (e.we) m_rf[rd] = e.data;
    m_z = e.z;
    m_c = e.c;
    send_byte({op, rd, rs1, rs2, 2'b00});
    first = last_accept;
    if (op == T_LDI) send_byte(imm);
  endtask

  // Completion monitor: every op_done pops one expectation
  always @(negedge clock) begin
    if (!reset && op_done) begin
      if (sb.size() == 0) check_eq("unexpected_done", 32'(op_done), 32'(0));
      else begin
        mon_e = sb.pop_front();
        check_eq("wb_we", 32'(rf_write_enable), 32'(mon_e.we));
        if (mon_e.we) begin
          check_eq("wb_reg", 32'(rf_write_register), 32'(mon_e.rd));
          check_eq("wb_data", 32'(rf_write_data), 32'(mon_e.data));
        end
        check_eq("flag_zero", 32'(flag_zero), 32'(mon_e.z));
        check_eq("flag_carry", 32'(flag_carry), 32'(mon_e.c));
      end
    end
    if (rf_write_enable && !op_done) check_eq("we_without_done", 32'(rf_write_enable), 32'(0));
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; last_accept = 0;
    m_rf[0] = 8'h00; m_rf[1] = 8'h00; m_z = 1'b0; m_c = 1'b0;
    reset = 1'b1; instr_valid = 1'b0; instr_data = 8'h00;

    // Reset behaviour
    repeat (3) @(negedge clock);
    check_eq("ready_in_reset", 32'(instr_ready), 32'(0));
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_ready", 32'(instr_ready), 32'(1));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_done", 32'(op_done), 32'(0));
    check_eq("rst_we", 32'(rf_write_enable), 32'(0));
    check_eq("rst_flags", 32'({flag_zero, flag_carry}), 32'(0));
    check_eq("rst_rd_sel", 32'({rf_read_register1, rf_read_register2}), 32'(0));

    // LDI r0,0x05 then ADD carry case
    send_instr(T_LDI, 1'b0, 1'b0, 1'b0, 8'h05, first_acc);
    send_instr(T_LDI, 1'b0, 1'b0, 1'b0, 8'hF0, first_acc);
    send_instr(T_LDI, 1'b1, 1'b0, 1'b0, 8'h20, first_acc);
    send_instr(T_ADD, 1'b1, 1'b0, 1'b1, 8'h00, first_acc);

    // SUB to zero, then SUB with borrow
    send_instr(T_LDI, 1'b0, 1'b0, 1'b0, 8'h10, first_acc);
    send_instr(T_LDI, 1'b1, 1'b0, 1'b0, 8'h10, first_acc);
    send_instr(T_SUB, 1'b0, 1'b0, 1'b1, 8'h00, first_acc);
    send_instr(T_SUB, 1'b0, 1'b0, 1'b1, 8'h00, first_acc);

    // LDI held in IMM with no valid byte for five cycles
    begin
      exp_t e;
      e = model_op(T_LDI, 1'b1, 1'b1, 1'b1, 8'hAA);
      sb.push_back(e);
      m_rf[1] = e.data;
      send_byte({T_LDI, 1'b1, 1'b1, 1'b1, 2'b00});
      @(negedge clock);
      instr_valid = 1'b0;
      repeat (5) begin
        check_eq("imm_ready", 32'(instr_ready), 32'(1));
        check_eq("imm_busy", 32'(busy), 32'(1));
        check_eq("imm_rd_sel", 32'({rf_read_register1, rf_read_register2}), 32'(0));
        check_eq("imm_we", 32'(rf_write_enable), 32'(0));
        @(negedge clock);
      end
      send_byte(8'hAA);
    end

    // Latency of a non-LDI instruction: EXEC, WB, then FETCH
    send_instr(T_MOV, 1'b0, 1'b1, 1'b0, 8'h00, first_acc);
    @(negedge clock);
    instr_valid = 1'b0;
    check_eq("lat_exec_busy", 32'(busy), 32'(1));
    check_eq("lat_exec_done", 32'(op_done), 32'(0));
    check_eq("lat_exec_rs1", 32'(rf_read_register1), 32'(1));
    @(negedge clock);
    check_eq("lat_wb_done", 32'(op_done), 32'(1));
    @(negedge clock);
    check_eq("lat_fetch_ready", 32'(instr_ready), 32'(1));
    check_eq("lat_fetch_busy", 32'(busy), 32'(0));

    // Reset during the WB cycle of an ADD that produces carry
    rst_e = model_op(T_ADD, 1'b1, 1'b0, 1'b1, 8'h00);
    send_byte({T_ADD, 1'b1, 1'b0, 1'b1, 2'b00});
    @(negedge clock);
    instr_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_eq("rwb_we", 32'(rf_write_enable), 32'(0));
    check_eq("rwb_done", 32'(op_done), 32'(0));
    check_eq("rwb_ready", 32'(instr_ready), 32'(0));
    check_eq("rwb_carry_pre", 32'(flag_carry), 32'(rst_e.c));
    @(negedge clock);
    check_eq("rwb_flags", 32'({flag_zero, flag_carry}), 32'(0));
    check_eq("rwb_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    m_z = 1'b0; m_c = 1'b0;
    @(negedge clock);
    check_eq("rwb_ready_after", 32'(instr_ready), 32'(1));
    check_eq("rwb_rf_kept", 32'(rf[1]), 32'(m_rf[1]));

    // Back-to-back stream with valid held high, covering every opcode
    prev_end = 0;
    for (int i = 0; i < 24; i++) begin
      logic [2:0] op;
      op = 3'((i * 5 + 2) % 8);
      send_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom), first_acc);
      if (i > 0) check_eq("b2b_spacing", first_acc - prev_end, 32'(3));
      prev_end = last_accept;
    end
    @(negedge clock);
    instr_valid = 1'b0;

    // Drain outstanding expectations
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clock);
    check_eq("sb_drain", 32'(sb.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have ports: clock  input  1  system clock; reset  input  1  synchronous, active-high reset.
REQ-002 SHALL have port: instr_valid  input  1  upstream byte valid.
REQ-003 SHALL have port: instr_data  input  8  instruction or immediate byte.
REQ-004 SHALL have port: instr_ready  output  1  sequencer accepts a byte this cycle.
REQ-005 SHALL have ports: rf_read_register1, rf_read_register2  output  1 each  register file read selects.
REQ-006 SHALL have ports: rf_read_data1, rf_read_data2  input  8 each  combinational register file read data.
REQ-007 SHALL have ports: rf_write_enable  output  1; rf_write_register  output  1; rf_write_data  output  8.
REQ-008 SHALL have ports: busy  output  1  high whenever state is not FETCH; op_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports: flag_zero, flag_carry  output  1 each  ALU status.

Function
REQ-010 Byte transfer SHALL occur on a rising edge with instr_valid=1 and instr_ready=1; instr_ready SHALL be 1 only in FETCH and IMM.
REQ-011 Instruction format SHALL be: [7:5] opcode, [4] rd, [3] rs1, [2] rs2, [1:0] ignored.
REQ-012 Opcodes SHALL be: 000 NOP, 001 LDI (rd=next byte), 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 MOV (rd=rs1).
REQ-013 States SHALL be FETCH, IMM, EXEC, WB; FETCH->IMM on accepted LDI, FETCH->EXEC on any other accepted opcode, IMM->EXEC on accepted byte, EXEC->WB, WB->FETCH.
REQ-014 In EXEC, rf_read_register1=rs1 and rf_read_register2=rs2 SHALL be driven, and the result SHALL be registered at the end of EXEC.
REQ-015 In WB, rf_write_enable SHALL be 1 for exactly one cycle with rf_write_register=rd and rf_write_data=result; for NOP it SHALL stay 0.
REQ-016 op_done SHALL pulse in the WB cycle for every opcode, NOP included.
REQ-017 Latency: non-LDI byte accepted at edge N -> EXEC in cycle N+1, WB in cycle N+2, instr_ready high again in cycle N+3.
REQ-018 ADD/SUB SHALL be 8-bit modulo; ADD carry = bit 8 of the 9-bit sum; SUB carry = borrow (rs1 < rs2, unsigned).
REQ-019 AND/OR/XOR SHALL clear flag_carry; zero SHALL be set iff the 8-bit result == 0; flags SHALL update at the end of EXEC for ALU opcodes only (LDI/MOV/NOP preserve flags).
REQ-020 A write in WB SHALL be visible to the next instruction's EXEC; no forwarding or stall logic is required.
REQ-021 In IMM, instr_valid=0 SHALL hold the state indefinitely with no outputs changing.
REQ-022 rs1==rs2 and rd==rs1 SHALL be legal and SHALL use the pre-write operand values.
REQ-023 rf outputs SHALL be 0 outside EXEC/WB.

Reset
REQ-024 reset SHALL take priority over all activity, including mid-LDI and WB; a write pending in the reset cycle SHALL NOT occur.
REQ-025 After reset: state FETCH, flags 0, result 0, rf_write_enable 0, op_done 0, busy 0; instr_ready SHALL be 0 while reset is high and 1 in the first cycle after reset.

Structure
REQ-026 A shared package SHALL hold opcode constants, the state encoding, and the instruction field bit positions.
REQ-027 Sub-module alu8 SHALL be combinational (opcode, a, b -> result[7:0], carry, zero) and instantiated once.

Verification
REQ-028 LDI r0 with byte 0x05 -> rf_write_enable in WB, register 0, data 0x05; flags unchanged; op_done once.
REQ-029 r0=0xF0, r1=0x20, ADD r1,r0,r1 -> write 0x10 to r1; carry=1; zero=0.
REQ-030 r0=0x10, r1=0x10, SUB r0,r0,r1 -> write 0x00; zero=1; carry=0; then SUB with r0=0x00, r1=0x10 -> 0xF0, carry=1.
REQ-031 LDI opcode accepted, instr_valid low for 5 cycles, then 0xAA -> stays in IMM with instr_ready=1, then writes 0xAA.
REQ-032 reset asserted in the WB cycle of ADD -> no rf_write_enable; flags 0; FETCH on release.
REQ-033 Back-to-back instructions with instr_valid held high -> one byte accepted per FETCH; ALU ops complete every 3 cycles; NOP produces op_done with no write.
